// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit -- instruction fetch (IF) stage
//
// Owns the fetch PC and issues word-aligned reads to instruction memory. It
// buffers returned instructions, each with its PC, in a DEPTH-entry FIFO and
// hands them to the decode (ID) stage under a valid/ready handshake. A
// redirect from EX (taken branch / jal / jalr) flushes the FIFO and restarts
// fetch at the new PC. If a memory request is in flight when the redirect
// arrives, that request is completed and its data is thrown away.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  fetch PC after reset
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   inst_read    out  I-mem read request, held until inst_resp
//   inst_addr    out  I-mem word address, stable while inst_read
//   inst_resp    in   I-mem response pulse, completes the request
//   inst_rdata   in   instruction word, valid with inst_resp
//   redirect     in   EX redirect pulse (flush + refetch)
//   redirect_pc  in   new fetch PC, bits [1:0] ignored
//   id_valid     out  id_instr / id_pc valid
//   id_ready     in   ID accepts this cycle
//   id_instr     out  instruction to decode
//   id_pc        out  PC of id_instr
//
// Optional feature macro: FETCH_BYPASS_EN
//   When defined, a response that arrives while the FIFO is empty is shown
//   on id_* in the same cycle. If ID takes it in that cycle, it is not
//   written into the FIFO. When the macro is undefined, id_* come only from
//   the FIFO head, so there is no combinational path from inst_* to id_*.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_read,
  output logic [31:0] inst_addr,
  input  logic        inst_resp,
  input  logic [31:0] inst_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int             PW      = $clog2(DEPTH);
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0]  PTR_ONE = PW'(1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];

  logic [31:0]   target_pc;
  logic          resp_ok;
  logic          fifo_nonempty;
  logic          bypass_take;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_nxt;
  logic          room;
  logic          unused_bits;

  // The low two bits of redirect_pc are dropped to keep fetch word aligned.
  assign target_pc   = {redirect_pc[31:2], 2'b00};
  assign unused_bits = ^redirect_pc[1:0];

  // A response is accepted only in WAIT and only when no redirect kills it.
  assign resp_ok       = (state == S_WAIT) && inst_resp && !redirect;
  assign fifo_nonempty = (count != {CW{1'b0}});

  // ID-side view: FIFO head, optionally overridden by the same-cycle bypass.
  always_comb begin
    id_valid    = fifo_nonempty && !redirect;
    id_instr    = fifo_instr[head];
    id_pc       = fifo_pc[head];
    bypass_take = 1'b0;
`ifdef FETCH_BYPASS_EN
    if (resp_ok && !fifo_nonempty) begin
      id_valid    = 1'b1;
      id_instr    = inst_rdata;
      id_pc       = fetch_pc;
      bypass_take = id_ready;
    end else begin
      bypass_take = 1'b0;
    end
`endif
  end

  // FIFO occupancy bookkeeping. A pop comes only from a real FIFO entry;
  // a bypassed instruction never enters the FIFO.
  always_comb begin
    pop       = fifo_nonempty && !redirect && id_ready;
    push      = resp_ok && !bypass_take;
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_ONE;
    end else if (pop && !push) begin
      count_nxt = count - CNT_ONE;
    end else begin
      count_nxt = count;
    end
    room = (count_nxt < DEPTH_C);
  end

  // FIFO storage, pointers and the fetch FSM with its registered outputs.
  // inst_addr also holds the address of the request in flight, so DISCARD
  // keeps presenting the old address after fetch_pc has been redirected.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      head      <= {PW{1'b0}};
      tail      <= {PW{1'b0}};
      count     <= {CW{1'b0}};
      inst_read <= 1'b0;
      inst_addr <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= 32'h0000_0000;
        fifo_pc[i]    <= 32'h0000_0000;
      end
    end else begin
      if (redirect) begin
        head  <= {PW{1'b0}};
        tail  <= {PW{1'b0}};
        count <= {CW{1'b0}};
      end else begin
        if (push) begin
          fifo_instr[tail] <= inst_rdata;
          fifo_pc[tail]    <= fetch_pc;
          tail             <= tail + PTR_ONE;
        end
        if (pop) begin
          head <= head + PTR_ONE;
        end
        count <= count_nxt;
      end

      case (state)
        S_IDLE: begin
          if (redirect) begin
            fetch_pc  <= target_pc;
            inst_addr <= target_pc;
          end else if (room) begin
            state     <= S_WAIT;
            inst_read <= 1'b1;
            inst_addr <= fetch_pc;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            fetch_pc <= target_pc;
            if (inst_resp) begin
              state     <= S_IDLE;
              inst_read <= 1'b0;
              inst_addr <= target_pc;
            end else begin
              // Request still outstanding: finish it and drop the data.
              state <= S_DISCARD;
            end
          end else if (inst_resp) begin
            fetch_pc  <= fetch_pc + 32'd4;
            inst_addr <= fetch_pc + 32'd4;
            if (room) begin
              state <= S_WAIT;
            end else begin
              state     <= S_IDLE;
              inst_read <= 1'b0;
            end
          end
        end
        S_DISCARD: begin
          if (redirect) begin
            fetch_pc <= target_pc;
          end
          if (inst_resp) begin
            state     <= S_IDLE;
            inst_read <= 1'b0;
            inst_addr <= redirect ? target_pc : fetch_pc;
          end
        end
        default: begin
          state     <= S_IDLE;
          inst_read <= 1'b0;
          inst_addr <= fetch_pc;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-programmable memory
// responder and a reference PC-stream model applied to every ID transfer.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        inst_resp = 1'b0;
  logic [31:0] inst_rdata = 32'h0000_0000;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int total = 0;
  int bad   = 0;
  int ntx   = 0;
  int nresp = 0;
  int cnt   = 0;
  int lat   = 1;
  int base  = 0;
  logic [31:0] exp_pc = 32'h0000_0060;
  logic [31:0] saved  = 32'h0000_0000;

  logic        s_rst   = 1'b1;
  logic        s_ready = 1'b1;
  logic        s_redir = 1'b0;
  logic [31:0] s_rpc   = 32'h0000_0000;

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .inst_read   (inst_read),
    .inst_addr   (inst_addr),
    .inst_resp   (inst_resp),
    .inst_rdata  (inst_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply stimulus at the falling edge, run the memory
  // responder, then check any ID transfer against the reference PC stream.
  task automatic cyc();
    @(negedge clk);
    rst         = s_rst;
    id_ready    = s_ready;
    redirect    = s_redir;
    redirect_pc = s_rpc;
    if (s_rst) begin
      inst_resp = 1'b0;
      cnt       = 0;
    end else begin
      if (inst_resp) begin
        inst_resp = 1'b0;
        cnt       = 0;
      end
      if (inst_read) begin
        cnt++;
        if (cnt > lat) begin
          inst_resp  = 1'b1;
          inst_rdata = mem(inst_addr);
        end
      end
    end
    #1;
    if (inst_resp) nresp++;
    if (s_rst) begin
      exp_pc = 32'h0000_0060;
    end else if (redirect) begin
      chk1("redirect_no_valid", id_valid, 1'b0);
      exp_pc = {redirect_pc[31:2], 2'b00};
    end else if (id_valid && id_ready) begin
      chk("stream_pc", id_pc, exp_pc);
      chk("stream_instr", id_instr, mem(exp_pc));
      exp_pc = exp_pc + 32'd4;
      ntx++;
    end
  endtask

  initial begin
    // 1: reset, then sequential fetch with 1-cycle memory
    s_rst = 1'b1; cyc(); cyc();
    s_rst = 1'b0; cyc();
    chk1("rst_inst_read", inst_read, 1'b0);
    chk("rst_inst_addr", inst_addr, 32'h0000_0060);
    chk1("rst_id_valid", id_valid, 1'b0);
    chk("rst_id_instr", id_instr, 32'h0000_0000);
    chk("rst_id_pc", id_pc, 32'h0000_0000);
    cyc();
    chk1("first_read", inst_read, 1'b1);
    chk("first_addr", inst_addr, 32'h0000_0060);
    cyc(); cyc();
    chk("first_ntx", ntx, 32'd1);
    chk("second_addr", inst_addr, 32'h0000_0064);
    repeat (10) cyc();
    chk("seq_ntx", ntx, 32'd6);

    // 2: ID stall fills the FIFO, then release drains it in order
    s_ready = 1'b0;
    base = nresp;
    repeat (20) cyc();
    chk("stall_pushes", nresp - base, 32'd4);
    chk1("stall_no_read", inst_read, 1'b0);
    chk1("stall_valid", id_valid, 1'b1);
    chk("stall_head_pc", id_pc, 32'h0000_0078);
    s_ready = 1'b1;
    base = ntx;
    cyc(); cyc();
    chk1("resume_read", inst_read, 1'b1);
    chk("resume_addr", inst_addr, 32'h0000_0088);
    repeat (4) cyc();
    chk("drain_ntx", ntx - base, 32'd6);

    // 3: redirect while WAIT, response arrives later -> DISCARD
    lat = 3;
    for (int i = 0; i < 40 && !(inst_read && cnt == 1 && !inst_resp); i++) cyc();
    chk1("t3_sync", inst_read && cnt == 1 && !inst_resp, 1'b1);
    s_redir = 1'b1; s_rpc = 32'h0000_0200;
    cyc();
    saved = inst_addr;
    s_redir = 1'b0;
    cyc();
    chk1("discard_read", inst_read, 1'b1);
    chk("discard_addr", inst_addr, saved);
    for (int i = 0; i < 20 && !inst_resp; i++) cyc();
    chk1("discard_resp_seen", inst_resp, 1'b1);
    chk1("discard_no_valid", id_valid, 1'b0);
    cyc();
    chk1("discard_idle", inst_read, 1'b0);
    cyc();
    chk1("refetch_read", inst_read, 1'b1);
    chk("refetch_addr", inst_addr, 32'h0000_0200);
    for (int i = 0; i < 20 && !id_valid; i++) cyc();
    chk("redirect_first_pc", id_pc, 32'h0000_0200);

    // 4: redirect coinciding with the response, unaligned target
    for (int i = 0; i < 40 && !(inst_read && cnt == 3 && !inst_resp); i++) cyc();
    chk1("t4_sync", inst_read && cnt == 3 && !inst_resp, 1'b1);
    s_redir = 1'b1; s_rpc = 32'h0000_1003;
    cyc();
    chk1("t4_resp_cycle", inst_resp, 1'b1);
    chk1("t4_no_valid", id_valid, 1'b0);
    s_redir = 1'b0;
    cyc();
    chk1("t4_idle", inst_read, 1'b0);
    chk1("t4_empty", id_valid, 1'b0);
    cyc();
    chk1("t4_read", inst_read, 1'b1);
    chk("t4_addr", inst_addr, 32'h0000_1000);
    for (int i = 0; i < 20 && !id_valid; i++) cyc();
    chk("t4_first_pc", id_pc, 32'h0000_1000);

    // 5: response latency to ID with an empty FIFO
    lat = 1;
    for (int i = 0; i < 20 && !inst_resp; i++) cyc();
    chk1("t5_resp", inst_resp, 1'b1);
    saved = inst_addr;
`ifdef FETCH_BYPASS_EN
    chk1("bypass_same_cycle", id_valid, 1'b1);
    chk("bypass_pc", id_pc, saved);
    cyc();
    chk1("bypass_not_pushed", id_valid, 1'b0);
`else
    chk1("nobypass_same_cycle", id_valid, 1'b0);
    cyc();
    chk1("nobypass_next_cycle", id_valid, 1'b1);
    chk("nobypass_pc", id_pc, saved);
`endif

    // 6: random stalls/redirects checked by the stream model
    s_redir = 1'b1; s_rpc = 32'hFFFF_FFF8;
    cyc();
    s_redir = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      s_ready = ($urandom_range(0, 3) != 0);
      s_redir = ($urandom_range(0, 29) == 0);
      s_rpc   = $urandom;
      if ($urandom_range(0, 49) == 0) lat = int'($urandom_range(0, 3));
      cyc();
    end
    s_redir = 1'b0; s_ready = 1'b1; lat = 1;
    base = ntx;
    repeat (20) cyc();
    chk1("random_live", ntx > base, 1'b1);

    // reset while a request is outstanding
    for (int i = 0; i < 20 && !(inst_read && !inst_resp); i++) cyc();
    chk1("t6_sync", inst_read && !inst_resp, 1'b1);
    s_rst = 1'b1; cyc();
    s_rst = 1'b0; cyc();
    chk1("midrst_valid", id_valid, 1'b0);
    chk1("midrst_read", inst_read, 1'b0);
    chk("midrst_addr", inst_addr, 32'h0000_0060);
    chk("midrst_id_pc", id_pc, 32'h0000_0000);
    base = ntx;
    repeat (20) cyc();
    chk1("midrst_live", ntx > base, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
